// File: rtl/temporal_encoder_if.sv
// -----------------------------------------------------------------------------
// temporal_encoder_if
// Input handshake bundle for temporal_encoder.
//   in_valid  : in_value/in_null are valid this cycle
//   in_ready  : encoder input buffer can accept
//   in_value  : spike time t, in aclk cycles from the start of the gamma cycle
//   in_null   : request "no spike" (infinity); in_value is ignored
// Modports: master (producer side), slave (encoder side).
// -----------------------------------------------------------------------------
interface temporal_encoder_if #(
    parameter int VALUE_WIDTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [VALUE_WIDTH-1:0] in_value;
    logic                   in_null;

    modport master (
        output in_valid,
        output in_value,
        output in_null,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_value,
        input  in_null,
        output in_ready
    );
endinterface

// File: rtl/temporal_encoder.sv
// -----------------------------------------------------------------------------
// temporal_encoder
// Binary-to-temporal (race-logic) transmitter. A binary value t is sent as a
// single spike whose onset lands at aclk cycle t of a gamma cycle. The encoder
// also generates the gamma-cycle reset strobe for downstream temporal logic.
// A value accepted during gamma cycle k is emitted in gamma cycle k+1.
//
// Ports:
//   aclk      : clock
//   grst      : asynchronous reset, active-high
//   en        : run request; gamma cycles are generated while high
//   in_if     : slave handshake (in_valid / in_ready / in_value / in_null)
//   gamma_rst : high for the first aclk cycle of every gamma cycle
//   q         : temporal-coded spike
//   clip      : one-cycle flag, accepted value was out of range and sent as null
//   busy      : encoder is running gamma cycles
//
// Optional feature (macro TEMPORAL_STEP_EN):
//   defined   : step encoding, q rises at cnt==t and stays high to the end of
//               the gamma cycle; every value fits, PULSE_WIDTH is unused
//   undefined : pulse encoding, q high for PULSE_WIDTH cycles starting at t
// -----------------------------------------------------------------------------
module temporal_encoder #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int VALUE_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic              aclk,
    input  logic              grst,
    input  logic              en,
    temporal_encoder_if.slave in_if,
    output logic              gamma_rst,
    output logic              q,
    output logic              clip,
    output logic              busy
);

    localparam logic [31:0] G_LAST = 32'(GAMMA_CYCLE_WIDTH - 1);
`ifdef TEMPORAL_STEP_EN
    localparam logic [31:0] MAX_T  = 32'(GAMMA_CYCLE_WIDTH - 1);
`else
    localparam logic [31:0] MAX_T  = 32'(GAMMA_CYCLE_WIDTH - PULSE_WIDTH);
    localparam logic [31:0] PW     = 32'(PULSE_WIDTH);
`endif
    localparam logic [VALUE_WIDTH-1:0] CNT_LAST = VALUE_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state, state_n;
    logic [VALUE_WIDTH-1:0] cnt, cnt_n;
    logic                   pending_full, pending_full_n;
    logic                   pending_null, pending_null_n;
    logic [VALUE_WIDTH-1:0] pending_value, pending_value_n;
    logic                   active_null, active_null_n;
    logic [VALUE_WIDTH-1:0] active_value, active_value_n;
    logic                   in_ready_r;
    logic                   gamma_rst_n, q_n, clip_n, busy_n;
    logic                   load;
    logic                   accept;
    logic                   out_of_range;
    logic                   incoming_null;
    logic [31:0]            spike_lo, spike_hi, cnt_ext;

    function automatic logic [31:0] zext(input logic [VALUE_WIDTH-1:0] v);
        return {{(32-VALUE_WIDTH){1'b0}}, v};
    endfunction

    assign in_if.in_ready = in_ready_r;

    // Next-state logic. "load" marks the edge that starts a new gamma cycle;
    // that is the only point where active changes, so a spike never straddles
    // a gamma boundary. Outputs are derived from the next-state values so the
    // registered q/gamma_rst line up with the registered cnt.
    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        load            = 1'b0;
        pending_full_n  = pending_full;
        pending_null_n  = pending_null;
        pending_value_n = pending_value;
        active_null_n   = active_null;
        active_value_n  = active_value;
        spike_lo        = '0;
        spike_hi        = '0;
        cnt_ext         = '0;

        accept        = in_if.in_valid && in_ready_r;
        out_of_range  = zext(in_if.in_value) > MAX_T;
        incoming_null = in_if.in_null || out_of_range;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (en) begin
                    state_n = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (en) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // accept cannot coincide with a load from pending since in_ready is low
        if (load) begin
            if (pending_full) begin
                active_null_n  = pending_null;
                active_value_n = pending_value;
                pending_full_n = 1'b0;
            end else if (accept) begin
                active_null_n  = incoming_null;
                active_value_n = in_if.in_value;
            end else begin
                active_null_n  = 1'b1;
            end
        end else if (accept) begin
            pending_full_n  = 1'b1;
            pending_null_n  = incoming_null;
            pending_value_n = in_if.in_value;
        end

        cnt_ext  = zext(cnt_n);
        spike_lo = zext(active_value_n);
`ifdef TEMPORAL_STEP_EN
        spike_hi = G_LAST;
`else
        spike_hi = spike_lo + PW - 32'd1;
`endif

        q_n         = (state_n == RUN) && !active_null_n &&
                      (cnt_ext >= spike_lo) && (cnt_ext <= spike_hi);
        gamma_rst_n = load;
        busy_n      = (state_n == RUN);
        clip_n      = accept && !in_if.in_null && out_of_range;
    end

    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            state         <= IDLE;
            cnt           <= '0;
            pending_full  <= 1'b0;
            pending_null  <= 1'b1;
            pending_value <= '0;
            active_null   <= 1'b1;
            active_value  <= '0;
            in_ready_r    <= 1'b1;
            gamma_rst     <= 1'b0;
            q             <= 1'b0;
            clip          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            pending_full  <= pending_full_n;
            pending_null  <= pending_null_n;
            pending_value <= pending_value_n;
            active_null   <= active_null_n;
            active_value  <= active_value_n;
            in_ready_r    <= !pending_full_n;
            gamma_rst     <= gamma_rst_n;
            q             <= q_n;
            clip          <= clip_n;
            busy          <= busy_n;
        end
    end

endmodule

// File: tb/tb_temporal_encoder.sv
// -----------------------------------------------------------------------------
// tb_temporal_encoder
// Self-checking bench for temporal_encoder (G=16, PW=8). A gamma-cycle level
// model (phase counter, pending queue, current spike time) predicts every
// output; a negedge compare process checks the DUT each cycle. Directed
// literal checks pin the first spike shape, clip and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_temporal_encoder;

    localparam int G  = 16;
    localparam int PW = 8;
    localparam int VW = $clog2(G);
`ifdef TEMPORAL_STEP_EN
    localparam int MAX_T = G - 1;
`else
    localparam int MAX_T = G - PW;
`endif

    logic aclk;
    logic grst;
    logic en;
    logic gamma_rst, q, clip, busy;

    temporal_encoder_if #(.VALUE_WIDTH(VW)) in_if ();

    temporal_encoder #(
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH      (PW),
        .VALUE_WIDTH      (VW)
    ) dut (
        .aclk     (aclk),
        .grst     (grst),
        .en       (en),
        .in_if    (in_if),
        .gamma_rst(gamma_rst),
        .q        (q),
        .clip     (clip),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // ---------------- behavioural model ----------------
    bit running   = 0;
    int phase     = 0;
    int cur_t     = -1;
    int pend[$];
    bit exp_q     = 0;
    bit exp_gamma = 0;
    bit exp_clip  = 0;
    bit exp_busy  = 0;
    bit exp_ready = 1;

    always @(posedge aclk or posedge grst) begin
        bit acc;
        bit new_cycle;
        int v;
        int hi;
        if (grst) begin
            running   = 0;
            phase     = 0;
            cur_t     = -1;
            pend.delete();
            exp_q     = 0;
            exp_gamma = 0;
            exp_clip  = 0;
            exp_busy  = 0;
            exp_ready = 1;
        end else begin
            acc = in_if.in_valid && (pend.size() == 0);
            v   = (in_if.in_null || int'(in_if.in_value) > MAX_T) ? -1 : int'(in_if.in_value);
            new_cycle = 0;
            if (!running) begin
                if (en) begin
                    running   = 1;
                    phase     = 0;
                    new_cycle = 1;
                end
            end else if (phase == G - 1) begin
                phase = 0;
                if (en) new_cycle = 1;
                else    running   = 0;
            end else begin
                phase = phase + 1;
            end
            if (new_cycle) begin
                if (pend.size() != 0) cur_t = pend.pop_front();
                else if (acc)         cur_t = v;
                else                  cur_t = -1;
            end else if (acc) begin
                pend.push_back(v);
            end
`ifdef TEMPORAL_STEP_EN
            hi = G - 1;
`else
            hi = cur_t + PW - 1;
`endif
            exp_q     = running && (cur_t >= 0) && (phase >= cur_t) && (phase <= hi);
            exp_gamma = new_cycle;
            exp_clip  = acc && !in_if.in_null && (int'(in_if.in_value) > MAX_T);
            exp_busy  = running;
            exp_ready = (pend.size() == 0);
        end
    end

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic v, input int val, input logic n);
        en             = e;
        in_if.in_valid = v;
        in_if.in_value = VW'(val);
        in_if.in_null  = n;
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge aclk) begin
        if (!grst) begin
            checkOutput("q",         q,              exp_q);
            checkOutput("gamma_rst", gamma_rst,      exp_gamma);
            checkOutput("clip",      clip,           exp_clip);
            checkOutput("busy",      busy,           exp_busy);
            checkOutput("in_ready",  in_if.in_ready, exp_ready);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] dut_q_vec, mdl_q_vec, dut_g_vec, exp_vec;
        bit found;
        bit en_r;

        grst = 1'b1;
        applyStimulus(0, 0, 0, 0);
        repeat (3) @(negedge aclk);
        checkOutput("reset_q",     q,              1'b0);
        checkOutput("reset_gamma", gamma_rst,      1'b0);
        checkOutput("reset_busy",  busy,           1'b0);
        checkOutput("reset_ready", in_if.in_ready, 1'b1);
        grst = 1'b0;

        // Accept t=3 while idle, then start running.
        @(negedge aclk);
        applyStimulus(0, 1, 3, 0);
        @(negedge aclk);
        checkOutput("ready_after_accept", in_if.in_ready, 1'b0);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < G; i++) begin
            @(negedge aclk);
            dut_q_vec[i] = q;
            mdl_q_vec[i] = exp_q;
            dut_g_vec[i] = gamma_rst;
            if (i == 0) checkOutput("ready_after_load", in_if.in_ready, 1'b1);
        end
`ifdef TEMPORAL_STEP_EN
        exp_vec = 16'hFFF8;
`else
        exp_vec = 16'h07F8;
`endif
        checks++;
        if (dut_q_vec !== exp_vec) begin
            errors++;
            $display("[TB] FAIL first_spike_dut: got %h expected %h", dut_q_vec, exp_vec);
        end
        checks++;
        if (mdl_q_vec !== exp_vec) begin
            errors++;
            $display("[TB] FAIL first_spike_model: got %h expected %h", mdl_q_vec, exp_vec);
        end
        checks++;
        if (dut_g_vec !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL first_gamma_rst: got %h expected 0001", dut_g_vec);
        end

        // t=9 at the wrap edge: out of range for pulse mode.
        applyStimulus(1, 1, 9, 0);
        @(negedge aclk);
`ifdef TEMPORAL_STEP_EN
        checkOutput("clip_t9", clip, 1'b0);
`else
        checkOutput("clip_t9", clip, 1'b1);
`endif
        applyStimulus(1, 0, 0, 0);
        @(negedge aclk);
        checkOutput("clip_one_cycle", clip, 1'b0);

        // Queue t=2, wait for its spike, then reset mid-spike.
        applyStimulus(1, 1, 2, 0);
        @(negedge aclk);
        applyStimulus(1, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge aclk);
            if (q === 1'b1) found = 1;
        end
        checkOutput("spike_seen_before_reset", found, 1'b1);
        #2;
        grst = 1'b1;
        applyStimulus(0, 0, 0, 0);
        #1;
        checkOutput("async_reset_q",    q,    1'b0);
        checkOutput("async_reset_busy", busy, 1'b0);
        @(negedge aclk);
        grst = 1'b0;
        @(negedge aclk);
        checkOutput("post_reset_ready", in_if.in_ready, 1'b1);
        checkOutput("post_reset_q",     q,              1'b0);
        checkOutput("post_reset_busy",  busy,           1'b0);

        // Randomized traffic with occasional en drops and one mid-run reset.
        en_r = 1;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 49) == 0) en_r = !en_r;
            applyStimulus(en_r, ($urandom_range(0, 2) == 0), int'($urandom_range(0, G - 1)),
                          ($urandom_range(0, 5) == 0));
            @(negedge aclk);
            if (i == 450) begin
                #3;
                grst = 1'b1;
                #1;
                checkOutput("random_reset_q", q, 1'b0);
                @(negedge aclk);
                grst = 1'b0;
            end
        end

        applyStimulus(0, 0, 0, 0);
        repeat (2 * G) @(negedge aclk);
        checkOutput("final_idle_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
